// File: rtl/alb_sequencer_if.sv
// Command/response bundle between the control path and alb_sequencer.
//
// Handshake rule, applying to both the cmd and rsp channels: a transfer
// happens on a rising clk edge where valid and ready are both 1. The
// producer holds its payload stable while valid=1 and ready=0. The
// consumer may raise ready without waiting for valid.
//
// Signals:
//   cmd_valid/cmd_ready  command handshake
//   cmd_op               ALB function code (2 bits)
//   cmd_len              operand length minus one
//   cmd_ci               carry-in for byte 0
//   cmd_chain            1: carry ripples byte to byte; 0: every byte uses cmd_ci
//   cmd_a/cmd_b          operands, byte k at bits [8k+7:8k]
//   rsp_valid/rsp_ready  response handshake
//   rsp_f                assembled result
//   rsp_co/no/vo         flags of the last byte; rsp_zo is the whole-width zero flag
interface alb_sequencer_if #(
  parameter int MAX_BYTES = 4
);
  localparam int LW = $clog2(MAX_BYTES);

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic [LW-1:0]          cmd_len;
  logic                   cmd_ci;
  logic                   cmd_chain;
  logic [8*MAX_BYTES-1:0] cmd_a;
  logic [8*MAX_BYTES-1:0] cmd_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [8*MAX_BYTES-1:0] rsp_f;
  logic                   rsp_co;
  logic                   rsp_zo;
  logic                   rsp_no;
  logic                   rsp_vo;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_ci, cmd_chain, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_f, rsp_co, rsp_zo, rsp_no, rsp_vo
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_ci, cmd_chain, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_f, rsp_co, rsp_zo, rsp_no, rsp_vo
  );
endinterface

// File: rtl/alb_sequencer.sv
// Multi-byte operation sequencer for the 8-bit combinational ALB.
// Takes one command over bus (slave side), drives the ALB one byte per
// cycle least-significant byte first, optionally ripples CO into the next
// CI, and returns the assembled result plus aggregate flags over bus.
//
// Ports:
//   clk, resetb      clock; asynchronous active-high reset
//   bus              alb_sequencer_if.slave command/response channels
//   R, S, CI, ALB_MI registered drive to the ALB
//   F, CO, ZO, NO, VO ALB outputs, sampled at the end of the drive cycle
//   busy             high while a command is in RUN or DONE
//   fsm_state        current FSM state (0 IDLE, 1 RUN, 2 DONE)
module alb_sequencer #(
  parameter int MAX_BYTES = 4
) (
  input  logic       clk,
  input  logic       resetb,
  alb_sequencer_if.slave bus,
  output logic [7:0] R,
  output logic [7:0] S,
  output logic       CI,
  output logic [1:0] ALB_MI,
  input  logic [7:0] F,
  input  logic       CO,
  input  logic       ZO,
  input  logic       NO,
  input  logic       VO,
  output logic       busy,
  output logic [1:0] fsm_state
);
  localparam int LW = $clog2(MAX_BYTES);
  localparam int W  = 8 * MAX_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0]    op_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx_q;
  logic [LW-1:0] nidx;
  logic          ci_q;
  logic          chain_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  f_q;
  logic          zacc_q;
  logic          rsp_co_q, rsp_zo_q, rsp_no_q, rsp_vo_q;
  logic [7:0]    r_q, s_q;
  logic          ci_drv_q;
  logic [1:0]    mi_q;

  logic cmd_ready, rsp_valid;
  logic accept, last;

  assign accept = (state_q == IDLE) && bus.cmd_valid && !resetb;
  assign last   = (state_q == RUN) && (idx_q == len_q);
  assign nidx   = idx_q + LW'(1);

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by reset so the channel reads not-ready while reset is held.
        cmd_ready = !resetb;
        if (bus.cmd_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The ALB drive is registered one cycle ahead: on acceptance it is loaded
  // with byte 0, during RUN with the next byte, and cleared after the last
  // byte, so R/S/CI/ALB_MI leave flops and are zero outside RUN.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      op_q     <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      ci_q     <= 1'b0;
      chain_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      f_q      <= '0;
      zacc_q   <= 1'b0;
      rsp_co_q <= 1'b0;
      rsp_zo_q <= 1'b0;
      rsp_no_q <= 1'b0;
      rsp_vo_q <= 1'b0;
      r_q      <= '0;
      s_q      <= '0;
      ci_drv_q <= 1'b0;
      mi_q     <= '0;
    end else if (accept) begin
      op_q     <= bus.cmd_op;
      len_q    <= bus.cmd_len;
      ci_q     <= bus.cmd_ci;
      chain_q  <= bus.cmd_chain;
      a_q      <= bus.cmd_a;
      b_q      <= bus.cmd_b;
      idx_q    <= '0;
      zacc_q   <= 1'b1;
      f_q      <= '0;
      r_q      <= bus.cmd_a[7:0];
      s_q      <= bus.cmd_b[7:0];
      ci_drv_q <= bus.cmd_ci;
      mi_q     <= bus.cmd_op;
    end else if (state_q == RUN) begin
      f_q[8*idx_q +: 8] <= F;
      zacc_q            <= zacc_q & ZO;
      if (last) begin
        rsp_co_q <= CO;
        rsp_no_q <= NO;
        rsp_vo_q <= VO;
        rsp_zo_q <= zacc_q & ZO;
        r_q      <= '0;
        s_q      <= '0;
        ci_drv_q <= 1'b0;
        mi_q     <= '0;
      end else begin
        idx_q    <= nidx;
        r_q      <= a_q[8*nidx +: 8];
        s_q      <= b_q[8*nidx +: 8];
        // This cycle's CO is the carry into the next byte when chaining.
        ci_drv_q <= chain_q ? CO : ci_q;
        mi_q     <= op_q;
      end
    end
  end

  assign R      = r_q;
  assign S      = s_q;
  assign CI     = ci_drv_q;
  assign ALB_MI = mi_q;

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_f     = f_q;
  assign bus.rsp_co    = rsp_co_q;
  assign bus.rsp_zo    = rsp_zo_q;
  assign bus.rsp_no    = rsp_no_q;
  assign bus.rsp_vo    = rsp_vo_q;
  assign fsm_state     = state_q;
endmodule

// File: tb/tb_alb_sequencer.sv
module tb_alb_sequencer;
  localparam int MB = 4;
  localparam int LW = 2;
  localparam int W  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetb;
  always #5 clk = ~clk;

  alb_sequencer_if #(.MAX_BYTES(MB)) bus();

  logic [7:0] R, S, F;
  logic       CI, CO, ZO, NO, VO, busy;
  logic [1:0] ALB_MI, fsm_state;
  logic [8:0] alb_sum;

  alb_sequencer #(.MAX_BYTES(MB)) dut (
    .clk(clk), .resetb(resetb), .bus(bus),
    .R(R), .S(S), .CI(CI), .ALB_MI(ALB_MI),
    .F(F), .CO(CO), .ZO(ZO), .NO(NO), .VO(VO),
    .busy(busy), .fsm_state(fsm_state)
  );

  // Bench ALB: 00 add with carry, 01 and, 10 or, 11 xor.
  always_comb begin
    alb_sum = {1'b0, R} + {1'b0, S} + {8'b0, CI};
    F  = 8'h00;
    CO = 1'b0;
    VO = 1'b0;
    case (ALB_MI)
      2'b00: begin
        F  = alb_sum[7:0];
        CO = alb_sum[8];
        VO = (R[7] == S[7]) && (alb_sum[7] != R[7]);
      end
      2'b01:   F = R & S;
      2'b10:   F = R | S;
      default: F = R ^ S;
    endcase
    ZO = (F == 8'h00);
    NO = F[7];
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0]    op;
    logic [LW-1:0] len;
    logic          ci;
    logic          chain;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  f;
    logic          co;
    logic          zo;
    logic          no;
    logic          vo;
  } vec_t;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Whole-width reference: the command as one arithmetic operation.
  function automatic vec_t model(input vec_t v);
    int nbits;
    int t;
    logic [63:0] mask, s, f;
    nbits = 8 * (int'(v.len) + 1);
    mask  = (64'h1 << nbits) - 64'h1;
    v.co  = 1'b0;
    v.vo  = 1'b0;
    if (v.op == 2'b00) begin
      if (v.chain) begin
        s = ({32'b0, v.a} & mask) + ({32'b0, v.b} & mask) + {63'b0, v.ci};
        f = s & mask;
        v.co = s[nbits];
        v.vo = (v.a[nbits-1] == v.b[nbits-1]) && (f[nbits-1] != v.a[nbits-1]);
      end else begin
        f = 64'h0;
        for (int k = 0; k <= int'(v.len); k++) begin
          t = int'(v.a[8*k +: 8]) + int'(v.b[8*k +: 8]) + int'(v.ci);
          f = f | (64'(t & 255) << (8*k));
          if (k == int'(v.len)) begin
            v.co = t[8];
            v.vo = (v.a[8*k+7] == v.b[8*k+7]) && (t[7] != v.a[8*k+7]);
          end
        end
      end
    end else if (v.op == 2'b01) begin
      f = {32'b0, v.a & v.b} & mask;
    end else if (v.op == 2'b10) begin
      f = {32'b0, v.a | v.b} & mask;
    end else begin
      f = {32'b0, v.a ^ v.b} & mask;
    end
    v.f  = f[W-1:0];
    v.zo = (f == 64'h0);
    v.no = f[nbits-1];
    return v;
  endfunction

  // Carry the ALB should see on byte k.
  function automatic logic exp_ci(input vec_t v, input int k);
    logic [63:0] mask, s;
    if (k == 0 || !v.chain) return v.ci;
    if (v.op != 2'b00) return 1'b0;
    mask = (64'h1 << (8*k)) - 64'h1;
    s = ({32'b0, v.a} & mask) + ({32'b0, v.b} & mask) + {63'b0, v.ci};
    return s[8*k];
  endfunction

  // ---------------- driver ----------------
  task automatic run_cmd(input vec_t v, input int hold);
    int cnt, k, bad;
    logic [W-1:0] expf;
    bus.rsp_ready = (hold == 0);
    cnt = 0;
    @(negedge clk);
    while (!bus.cmd_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.cmd_ready) begin
      check("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
      return;
    end
    bus.cmd_op    = v.op;
    bus.cmd_len   = v.len;
    bus.cmd_ci    = v.ci;
    bus.cmd_chain = v.chain;
    bus.cmd_a     = v.a;
    bus.cmd_b     = v.b;
    bus.cmd_valid = 1'b1;
    exp_q.push_back(v.f);
    @(posedge clk);
    #1;
    // Scramble the command after acceptance; it must have no effect.
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = $urandom;
    bus.cmd_b     = $urandom;
    bus.cmd_ci    = ~v.ci;
    bus.cmd_chain = ~v.chain;
    bus.cmd_len   = LW'($urandom_range(0, MB-1));
    bus.cmd_op    = 2'($urandom_range(0, 3));
    bad = 0;
    for (cnt = 1; cnt <= 20; cnt++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
      k = cnt - 1;
      if (k > int'(v.len)) bad++;
      else if (R !== v.a[8*k +: 8] || S !== v.b[8*k +: 8] ||
               ALB_MI !== v.op || CI !== exp_ci(v, k) || busy !== 1'b1)
        bad++;
    end
    check("alb_drive", 64'(bad), 64'd0);
    check("latency", 64'(cnt), 64'(int'(v.len) + 2));
    expf = exp_q.pop_front();
    if (!bus.rsp_valid) return;
    check("rsp_f", 64'(bus.rsp_f), 64'(expf));
    check("rsp_flags", {60'b0, bus.rsp_co, bus.rsp_zo, bus.rsp_no, bus.rsp_vo},
          {60'b0, v.co, v.zo, v.no, v.vo});
    check("done_ready_busy", {62'b0, bus.cmd_ready, busy}, 64'b01);
    if (hold > 0) begin
      bad = 0;
      for (int i = 0; i < hold; i++) begin
        if (i == 2) begin
          bus.cmd_valid = 1'b1;
          bus.cmd_len   = '0;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        if (!bus.rsp_valid || bus.cmd_ready || bus.rsp_f !== expf ||
            bus.rsp_co !== v.co || bus.rsp_zo !== v.zo ||
            bus.rsp_no !== v.no || bus.rsp_vo !== v.vo)
          bad++;
      end
      check("backpressure_hold", 64'(bad), 64'd0);
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_after", {61'b0, busy, bus.rsp_valid, bus.cmd_ready}, 64'b001);
    check("alb_idle_drive", {45'b0, R, S, CI, ALB_MI}, 64'd0);
  endtask

  // ---------------- test ----------------
  vec_t tbl[11];
  vec_t v;
  int hi_cnt;

  initial begin
    tbl[0]  = '{2'd0, 2'd0, 1'b0, 1'b0, 32'h0000007F, 32'h00000001, 32'h00000080, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{2'd0, 2'd3, 1'b0, 1'b1, 32'h00FFFFFF, 32'h00000001, 32'h01000000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{2'd0, 2'd1, 1'b0, 1'b1, 32'h00000100, 32'h0000FF00, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{2'd0, 2'd1, 1'b0, 1'b0, 32'h00000100, 32'h0000FF00, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{2'd0, 2'd1, 1'b0, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{2'd0, 2'd1, 1'b0, 1'b1, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{2'd0, 2'd3, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{2'd3, 2'd1, 1'b0, 1'b1, 32'h00001234, 32'h00001234, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{2'd0, 2'd2, 1'b0, 1'b1, 32'hAA112233, 32'h55000000, 32'h00112233, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{2'd0, 2'd0, 1'b1, 1'b0, 32'h0000007F, 32'h00000000, 32'h00000080, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{2'd1, 2'd1, 1'b0, 1'b0, 32'h0000F0F0, 32'h0000FF0F, 32'h0000F000, 1'b0, 1'b0, 1'b1, 1'b0};

    resetb        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_len   = '0;
    bus.cmd_ci    = 1'b0;
    bus.cmd_chain = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready_valid_busy", {61'b0, bus.cmd_ready, bus.rsp_valid, busy}, 64'd0);
    check("reset_rsp", {28'b0, bus.rsp_f, bus.rsp_co, bus.rsp_zo, bus.rsp_no, bus.rsp_vo}, 64'd0);
    check("reset_alb_drive", {45'b0, R, S, CI, ALB_MI}, 64'd0);
    resetb = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(bus.cmd_ready), 64'd1);

    // Directed vectors.
    for (int i = 0; i < 11; i++) run_cmd(tbl[i], 0);

    // Backpressure with a stray cmd_valid pulse during DONE.
    run_cmd(tbl[1], 5);

    // Abort: reset during the second RUN cycle of a 4-byte command.
    @(negedge clk);
    bus.cmd_op = 2'd0; bus.cmd_len = 2'd3; bus.cmd_ci = 1'b0; bus.cmd_chain = 1'b1;
    bus.cmd_a = 32'h12345678; bus.cmd_b = 32'h11111111;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    resetb = 1'b1;
    #1;
    check("abort_state", {61'b0, busy, bus.rsp_valid, bus.cmd_ready}, 64'd0);
    check("abort_alb_drive", {45'b0, R, S, CI, ALB_MI}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    resetb = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || busy) hi_cnt++;
    end
    check("abort_no_response", 64'(hi_cnt), 64'd0);
    run_cmd(tbl[6], 0);

    // Randomized commands against the whole-width model.
    for (int i = 0; i < 40; i++) begin
      v.op    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      v.len   = LW'($urandom_range(0, MB-1));
      v.ci    = 1'($urandom_range(0, 1));
      v.chain = 1'($urandom_range(0, 1));
      v.a     = $urandom;
      v.b     = (i % 5 == 0) ? (~v.a + 32'd1) : $urandom;
      v = model(v);
      run_cmd(v, (i % 10 == 3) ? 3 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
